// File: rtl/uart_cmd_pkg.sv
// Shared types, opcodes, error codes and checksum helpers for the UART
// command frame controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_OP   = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_GET_CHK  = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  localparam logic [7:0] OP_WRITE          = 8'h01;
  localparam logic [7:0] OP_READ           = 8'h02;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_BADOP   = 2'd3;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  function automatic logic op_is_known(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter: cleared by clr, counts while run, and flags
// expire on the cycle the count reaches TIMEOUT_CYCLES-1 without a clear.
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 640
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Expiry decode; a byte in the same cycle (clr) always wins.
  always_comb begin
    expire = 1'b0;
    if (run && !clr && (cnt_r == LAST)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Idle-cycle counter, restarted on clear or expiry.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_r <= ZERO;
    end else if (clr || expire) begin
      cnt_r <= ZERO;
    end else if (run) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles SYNC/OP/ADDR/DATA/CHK frames from UART byte strobes and offers
// each good command on a valid/ready port; errors leave as one-cycle pulses.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 640
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       busy
);

  state_t     state_r;
  logic [7:0] chk_r;
  logic       in_get_s;
  logic       clr_s;
  logic       expire_s;

  // Timeout runs only while collecting frame bytes.
  always_comb begin
    in_get_s = 1'b0;
    case (state_r)
      ST_GET_OP, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: in_get_s = 1'b1;
      default:                                          in_get_s = 1'b0;
    endcase
    clr_s = rx_valid | ~in_get_s;
  end

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clr_s),
    .run   (in_get_s),
    .expire(expire_s)
  );

  // Frame FSM with registered command, error and busy outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r   <= ST_IDLE;
      chk_r     <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_op    <= 8'h00;
      cmd_addr  <= 8'h00;
      cmd_data  <= 8'h00;
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      busy      <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_r <= ST_GET_OP;
            chk_r   <= 8'h00;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        ST_GET_OP, ST_GET_ADDR, ST_GET_DATA: begin
          if (rx_valid) begin
            chk_r <= chk_update(chk_r, rx_data);
            if (state_r == ST_GET_OP) begin
              cmd_op  <= rx_data;
              state_r <= ST_GET_ADDR;
            end else if (state_r == ST_GET_ADDR) begin
              cmd_addr <= rx_data;
              state_r  <= ST_GET_DATA;
            end else begin
              cmd_data <= rx_data;
              state_r  <= ST_GET_CHK;
            end
          end else if (expire_s) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            state_r <= state_r;
          end
        end
        ST_GET_CHK: begin
          if (rx_valid) begin
            if (rx_data != chk_r) begin
              state_r   <= ST_IDLE;
              busy      <= 1'b0;
              err_valid <= 1'b1;
              err_code  <= ERR_CHK;
            end else if (!op_is_known(cmd_op)) begin
              state_r   <= ST_IDLE;
              busy      <= 1'b0;
              err_valid <= 1'b1;
              err_code  <= ERR_BADOP;
            end else begin
              state_r   <= ST_HOLD;
              cmd_valid <= 1'b1;
            end
          end else if (expire_s) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            state_r <= state_r;
          end
        end
        ST_HOLD: begin
          // On handshake, a coincident byte is handled as if already idle.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state_r <= ST_GET_OP;
              chk_r   <= 8'h00;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl; inputs change and outputs
// are sampled on the falling clock edge.
module tb_uart_cmd_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       err_valid;
  logic [1:0] err_code;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_cmd_ctrl #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .err_valid(err_valid),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // One-cycle strobe; returns on the falling edge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data, err_valid, err_code, busy} !== 29'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {cmd_valid, cmd_op, cmd_addr, cmd_data, err_valid, err_code, busy});
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    cmd_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h5C);
    checks++;
    if ({busy, cmd_valid} !== 2'b10) begin
      failures++; $display("FAIL good_pre_chk busy/valid got=%b exp=10", {busy, cmd_valid});
    end
    send_byte(8'h4D);
    checks++;
    if ({cmd_valid, err_valid} !== 2'b10) begin
      failures++; $display("FAIL good_valid valid/err got=%b exp=10", {cmd_valid, err_valid});
    end
    checks++;
    if ({cmd_op, cmd_addr, cmd_data} !== 24'h01105C) begin
      failures++; $display("FAIL good_fields got=%h exp=01105c", {cmd_op, cmd_addr, cmd_data});
    end
    @(negedge clk);
    checks++;
    if ({cmd_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL good_release valid/busy got=%b exp=00", {cmd_valid, busy});
    end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4E);
    checks++;
    if ({err_valid, err_code, cmd_valid, busy} !== 5'b1_00_0_0) begin
      failures++; $display("FAIL chk_err err/code/valid/busy got=%b exp=10000", {err_valid, err_code, cmd_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({err_valid, cmd_valid} !== 2'b00) begin
      failures++; $display("FAIL chk_pulse err/valid got=%b exp=00", {err_valid, cmd_valid});
    end
  endtask

  task automatic test_timeout();
    int cyc;
    send_byte(8'hA5); send_byte(8'h01);
    cyc = 1;
    while ((err_valid !== 1'b1) && (cyc < TO + 10)) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != TO + 1) begin
      failures++; $display("FAIL timeout_latency got=%0d exp=%0d", cyc, TO + 1);
    end
    checks++;
    if (err_code !== 2'd1) begin
      failures++; $display("FAIL timeout_code got=%0d exp=1", err_code);
    end
    @(negedge clk);
    checks++;
    if ({err_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL timeout_after err/busy got=%b exp=00", {err_valid, busy});
    end
    cmd_ready = 1'b1;
    send_frame(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data, err_code} !== {1'b1, 24'h01105C, 2'd1}) begin
      failures++; $display("FAIL timeout_recover got=%h exp=%h", {cmd_valid, cmd_op, cmd_addr, cmd_data, err_code}, {1'b1, 24'h01105C, 2'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout_boundary();
    cmd_ready = 1'b1;
    send_byte(8'hA5);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h01);
    checks++;
    if ({err_valid, busy} !== 2'b01) begin
      failures++; $display("FAIL boundary_byte_wins err/busy got=%b exp=01", {err_valid, busy});
    end
    send_byte(8'h10); send_byte(8'h5C); send_byte(8'h4D);
    checks++;
    if ({cmd_valid, err_valid, cmd_op} !== {2'b10, 8'h01}) begin
      failures++; $display("FAIL boundary_cmd got=%h exp=201", {cmd_valid, err_valid, cmd_op});
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    cmd_ready = 1'b0;
    send_frame(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D);
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_hold got=%b exp=1", cmd_valid);
    end
    send_byte(8'h33);
    checks++;
    if ({err_valid, err_code, cmd_valid} !== 4'b1_10_1) begin
      failures++; $display("FAIL overrun_err err/code/valid got=%b exp=1101", {err_valid, err_code, cmd_valid});
    end
    checks++;
    if ({cmd_op, cmd_addr, cmd_data} !== 24'h01105C) begin
      failures++; $display("FAIL overrun_fields got=%h exp=01105c", {cmd_op, cmd_addr, cmd_data});
    end
    @(negedge clk);
    checks++;
    if ({err_valid, cmd_valid} !== 2'b01) begin
      failures++; $display("FAIL overrun_pulse err/valid got=%b exp=01", {err_valid, cmd_valid});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL overrun_release valid/busy got=%b exp=00", {cmd_valid, busy});
    end
  endtask

  task automatic test_bad_opcode();
    send_frame(8'hA5, 8'h07, 8'h10, 8'h5C, 8'h4B);
    checks++;
    if ({err_valid, err_code, cmd_valid, busy} !== 5'b1_11_0_0) begin
      failures++; $display("FAIL badop err/code/valid/busy got=%b exp=11100", {err_valid, err_code, cmd_valid, busy});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b0;
    send_frame(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D);
    cmd_ready = 1'b1;
    send_byte(8'hA5);
    checks++;
    if ({cmd_valid, err_valid, busy} !== 3'b001) begin
      failures++; $display("FAIL b2b_accept_sync valid/err/busy got=%b exp=001", {cmd_valid, err_valid, busy});
    end
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h00); send_byte(8'h22);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data} !== {1'b1, 24'h022000}) begin
      failures++; $display("FAIL b2b_second_cmd got=%h exp=1022000", {cmd_valid, cmd_op, cmd_addr, cmd_data});
    end
    @(negedge clk);
  endtask

  task automatic test_garbage_reset();
    send_byte(8'h00); send_byte(8'hFF);
    checks++;
    if ({busy, err_valid, cmd_valid} !== 3'b000) begin
      failures++; $display("FAIL garbage_ignored busy/err/valid got=%b exp=000", {busy, err_valid, cmd_valid});
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data, err_valid, err_code, busy} !== 29'h0) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=0", {cmd_valid, cmd_op, cmd_addr, cmd_data, err_valid, err_code, busy});
    end
    n_rst = 1'b1;
    cmd_ready = 1'b1;
    send_frame(8'hA5, 8'h02, 8'h20, 8'h00, 8'h22);
    checks++;
    if ({cmd_valid, err_valid, cmd_op, cmd_addr, cmd_data} !== {2'b10, 24'h022000}) begin
      failures++; $display("FAIL read_after_reset got=%h exp=2022000", {cmd_valid, err_valid, cmd_op, cmd_addr, cmd_data});
    end
    @(negedge clk);
  endtask

  initial begin
    n_rst     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_bad_opcode();
    test_back_to_back();
    test_garbage_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
